// File: rtl/whack_game_ctrl.sv
// Whack-a-mole round sequencer: LFSR mole selection, timed hit window,
// pushbutton edge detection, saturating 0-9 score and 7-segment drive.
module whack_game_ctrl #(
  parameter int unsigned WINDOW = 50_000_000,
  parameter int unsigned GAP    = 12_500_000,
  parameter int unsigned ROUNDS = 10,
  parameter logic [7:0]  SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] pb,
  output logic [1:0] mole,
  output logic       hit,
  output logic [3:0] score,
  output logic [6:0] SEG,
  output logic       game_over
);

  localparam int unsigned TMAX = (WINDOW > GAP) ? WINDOW : GAP;
  localparam int unsigned TW   = $clog2(TMAX);
  localparam logic [TW-1:0] WIN_LAST = TW'(WINDOW - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP - 1);
  localparam logic [7:0]    ROUNDS_B = 8'(ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW,
    S_GAP,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [1:0]    mole_q, mole_d;
  logic          hit_q, hit_d;
  logic [3:0]    score_q, score_d;
  logic [7:0]    round_q, round_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    pb_q;

  logic [7:0] lfsr_step;
  logic [1:0] pb_rise;
  logic [7:0] round_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      mole_q  <= '0;
      hit_q   <= 1'b0;
      score_q <= '0;
      round_q <= '0;
      timer_q <= '0;
      pb_q    <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      mole_q  <= mole_d;
      hit_q   <= hit_d;
      score_q <= score_d;
      round_q <= round_d;
      timer_q <= timer_d;
      pb_q    <= pb;
    end
  end

  always_comb begin
    lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    pb_rise   = pb & ~pb_q;
    round_inc = round_q + 8'd1;

    state_d = state_q;
    lfsr_d  = lfsr_q;
    mole_d  = mole_q;
    hit_d   = 1'b0;
    score_d = score_q;
    round_d = round_q;
    timer_d = timer_q;

    case (state_q)
      S_IDLE: begin
        mole_d = '0;
        if (start) begin
          state_d = S_SHOW;
          lfsr_d  = lfsr_step;
          mole_d  = lfsr_step[0] ? 2'b10 : 2'b01;
          timer_d = '0;
        end
      end
      S_SHOW: begin
        // A hit takes priority over the window expiring on the same cycle.
        if (|(pb_rise & mole_q)) begin
          score_d = (score_q == 4'd9) ? 4'd9 : score_q + 4'd1;
          hit_d   = 1'b1;
          mole_d  = '0;
          state_d = S_GAP;
          timer_d = '0;
        end else if (timer_q == WIN_LAST) begin
          mole_d  = '0;
          state_d = S_GAP;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_GAP: begin
        mole_d = '0;
        if (timer_q == GAP_LAST) begin
          round_d = round_inc;
          timer_d = '0;
          if (round_inc == ROUNDS_B) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SHOW;
            lfsr_d  = lfsr_step;
            mole_d  = lfsr_step[0] ? 2'b10 : 2'b01;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DONE: begin
        mole_d = '0;
        if (start) begin
          score_d = '0;
          round_d = '0;
          state_d = S_SHOW;
          lfsr_d  = lfsr_step;
          mole_d  = lfsr_step[0] ? 2'b10 : 2'b01;
          timer_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        mole_d  = '0;
      end
    endcase
  end

  always_comb begin
    case (score_q)
      4'd0:    SEG = 7'b1000000;
      4'd1:    SEG = 7'b1111001;
      4'd2:    SEG = 7'b0100100;
      4'd3:    SEG = 7'b0110000;
      4'd4:    SEG = 7'b0011001;
      4'd5:    SEG = 7'b0010010;
      4'd6:    SEG = 7'b0000010;
      4'd7:    SEG = 7'b1111000;
      4'd8:    SEG = 7'b0000000;
      4'd9:    SEG = 7'b0011000;
      default: SEG = 7'b1111111;
    endcase
  end

  assign mole      = mole_q;
  assign hit       = hit_q;
  assign score     = score_q;
  assign game_over = (state_q == S_DONE);

endmodule

// File: doc/whack_game_ctrl.md
Name: whack_game_ctrl

Overview:
- Round sequencer for the whack-a-mole game.
- Each round it lights one of two moles from an 8-bit LFSR, opens a timed hit window, and edge-detects the two pushbuttons.
- It keeps a saturating 0-9 score, drives the active-low 7-segment digit, and flags game over after a fixed number of rounds.
- It sits between the debounced button inputs, the mole LEDs and the score display.

Parameters:
- WINDOW, 50_000_000, clock cycles a mole stays lit (hit window); must be ≥2.
- GAP, 12_500_000, clock cycles of dark time between rounds; must be ≥1.
- ROUNDS, 10, rounds per game; range 1..255.
- SEED, 8'hA5, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous active-high reset.
- start  in  1  level; sampled only in IDLE and DONE.
- pb  in  2  debounced pushbuttons, active-high, synchronous to clk.
- mole  out  2  one-hot mole LEDs; 2'b00 when no mole is lit.
- hit  out  1  one-cycle pulse per scored hit.
- score  out  4  binary score, 0..9.
- SEG  out  7  active-low 7-seg pattern of score, bit order {g,f,e,d,c,b,a}.
- game_over  out  1  high while in DONE.

Behaviour:
- Reset: state=IDLE, mole=0, hit=0, score=0, SEG=7'b1000000, game_over=0, lfsr=SEED, round=0, timer=0, pb_q=0.
- Button edge detection: pb_q registers pb each cycle; edge[i] = pb[i] & ~pb_q[i]. A button held through reset release produces one edge, which is ignored unless the state is SHOW.
- LFSR step: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - The LFSR steps exactly once on every entry into SHOW.
  - The stepped value selects the mole: mole = next[0] ? 2'b10 : 2'b01.
- IDLE: mole=0. If start=1, on the next cycle: state=SHOW, LFSR stepped, mole set, timer=0.
- SHOW: timer increments each cycle.
  - Hit: edge[i] & mole[i]. On the next cycle: score+1 (saturating at 9), hit=1 for that one cycle, mole=0, state=GAP, timer=0.
  - Wrong-button edges are ignored, with no penalty.
  - If both buttons edge together and one matches, it counts as a single hit.
  - Timeout: when timer==WINDOW-1 and there is no hit, the next cycle enters GAP with mole=0.
  - If a hit and the timeout coincide, the hit wins.
- GAP: mole=0 and timer increments.
  - At timer==GAP-1, round increments.
  - If the new round equals ROUNDS, go to DONE; otherwise go to SHOW with the LFSR stepped and timer=0.
- DONE: game_over=1, mole=0, score held.
  - If start=1, on the next cycle: score=0, round=0, game_over=0, state=SHOW with the LFSR stepped (LFSR not reseeded).
- start is ignored in SHOW and GAP. Holding start continuously restarts immediately from DONE.
- SEG is combinational from score, using 0..9 = 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0011000.
- Reset asserted mid-game returns all state to reset values immediately (asynchronous); it is not a hit.
- Counter widths: timer is $clog2(max(WINDOW,GAP)) bits; round is 8 bits.

Test Plan (WINDOW=8, GAP=4, ROUNDS=3, SEED=8'hA5):
- Reset, then pulse start -> the next cycle shows mole=01 (lfsr=8'h4A), score=0, SEG=1000000.
- Round 1: rising edge on pb[0] 3 cycles into SHOW -> hit high for exactly 1 cycle, score=1, SEG=1111001, mole=00 for 4 cycles. Round 2 then shows mole=10 (lfsr=8'h95).
- Round 2: press pb[0] only -> no hit. After 8 SHOW cycles mole=00, score stays 1. Round 3 shows mole=01 (lfsr=8'h2A).
- Round 3: pb[0] edge exactly on the timer==7 cycle -> hit counted, score=2. After the 4-cycle GAP, game_over=1, mole=00. Further pb edges change nothing. start -> score=0, game_over=0, SHOW.
- Saturation: ROUNDS=12, hit every round -> score climbs to 9, stays 9, SEG=0011000.
- Hold pb[1]=1 across reset release and through SHOW with mole=10 -> no hit, since there is no rising edge after IDLE. Assert reset mid-SHOW -> outputs go to reset values within the same cycle, before the next clock edge.
